// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: registers the fetch PC and presents IMEM read data to decode.
// Latency: pc_if -> pc_id 1 cycle; instr_if -> instr_id combinational (IMEM read aligns it).
// Backpressure: stall holds pc_id and replays the held instruction; redirect overrides stall.
//
// Optional build macro: IF_ID_PERF_CNT_EN enables the stall_cycles / squash_slots counters.
// When it is undefined both counter ports read 0 and no counter flops exist.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   pc_if, instr_if     PC issued to IMEM, IMEM data belonging to pc_id
//   stall, redirect     decode hold request, control-flow squash request
//   pc_id, instr_id     decode-stage PC and instruction
//   valid_id            decode slot holds a real (non-bubble) instruction
//   stall_cycles        count of cycles stalled without a redirect
//   squash_slots        count of cycles whose instruction was forced to a bubble
module if_id_pipe_reg #(
  parameter int              XLEN        = 32,
  parameter int              ILEN        = 32,
  parameter logic [ILEN-1:0] NOP_INSTR   = 32'h0000_0013,
  parameter int              FLUSH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_if,
  input  logic [ILEN-1:0] instr_if,
  input  logic            stall,
  input  logic            redirect,
  output logic [XLEN-1:0] pc_id,
  output logic [ILEN-1:0] instr_id,
  output logic            valid_id,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     squash_slots
);

  localparam int SQW = $clog2(FLUSH_DEPTH + 1);
  localparam logic [SQW-1:0] SQ_RELOAD = SQW'(FLUSH_DEPTH - 1);

  logic [XLEN-1:0] pc_q;
  logic [ILEN-1:0] hold_q;
  logic            replay_q;
  logic [SQW-1:0]  sq_cnt;
  logic            valid_q;

  logic            squash;
  logic            advance;

  // A slot advances only when decode accepts it and no redirect overrides it.
  assign advance = ~stall & ~redirect;
  assign squash  = redirect | (sq_cnt != '0);

  always_comb begin
    instr_id = instr_if;
    if (squash) begin
      instr_id = NOP_INSTR;
    end else if (replay_q) begin
      // IMEM data has moved on during the stall; present the captured copy.
      instr_id = hold_q;
    end
  end

  assign pc_id    = pc_q;
  assign valid_id = valid_q & ~squash;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      hold_q   <= NOP_INSTR;
      replay_q <= 1'b0;
      sq_cnt   <= '0;
      valid_q  <= 1'b0;
    end else begin
      hold_q   <= instr_id;
      replay_q <= stall & ~redirect;

      if (~stall | redirect) begin
        pc_q <= pc_if;
      end

      // A new redirect restarts the squash window even mid-squash; the
      // window is counted in slots that actually advance, so it freezes on stall.
      if (redirect) begin
        sq_cnt <= SQ_RELOAD;
      end else if (~stall && (sq_cnt != '0)) begin
        sq_cnt <= sq_cnt - SQW'(1);
      end

      if (advance) begin
        valid_q <= 1'b1;
      end
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] squash_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      if (stall && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (squash && (squash_cnt_q != 32'hFFFF_FFFF)) begin
        squash_cnt_q <= squash_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign squash_slots = squash_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign squash_slots = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_if = '0;
  logic [31:0] instr_if = NOP;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;

  logic [31:0] pc_id_a, instr_id_a, stall_cycles_a, squash_slots_a;
  logic        valid_id_a;
  logic [31:0] pc_id_b, instr_id_b, stall_cycles_b, squash_slots_b;
  logic        valid_id_b;

  always #5 clk = ~clk;

  if_id_pipe_reg #(.FLUSH_DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .pc_if(pc_if), .instr_if(instr_if),
    .stall(stall), .redirect(redirect),
    .pc_id(pc_id_a), .instr_id(instr_id_a), .valid_id(valid_id_a),
    .stall_cycles(stall_cycles_a), .squash_slots(squash_slots_a)
  );

  if_id_pipe_reg #(.FLUSH_DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .pc_if(pc_if), .instr_if(instr_if),
    .stall(stall), .redirect(redirect),
    .pc_id(pc_id_b), .instr_id(instr_id_b), .valid_id(valid_id_b),
    .stall_cycles(stall_cycles_b), .squash_slots(squash_slots_b)
  );

  typedef struct {
    int          sel;   // 1: FLUSH_DEPTH=2 instance, 2: FLUSH_DEPTH=3 instance
    int          id;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        vld;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step%0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step%0d observed=%b expected=%b", tag, step_no, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, queue the expected decode-stage view for that
  // cycle (sel=0: nothing expected), then compare at the falling edge.
  task automatic step(input logic r, input logic [31:0] p, input logic [31:0] i,
                      input logic s, input logic d, input int sel,
                      input logic [31:0] epc, input logic [31:0] ei, input logic ev);
    exp_t e;
    @(posedge clk);
    #1;
    step_no++;
    rst = r; pc_if = p; instr_if = i; stall = s; redirect = d;
    if (sel != 0) sb.push_back('{sel, step_no, epc, ei, ev});
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel == 1) begin
        chk32("a_pc_id", pc_id_a, e.pc);
        chk32("a_instr_id", instr_id_a, e.instr);
        chk1("a_valid_id", valid_id_a, e.vld);
      end else begin
        chk32("b_pc_id", pc_id_b, e.pc);
        chk32("b_instr_id", instr_id_b, e.instr);
        chk1("b_valid_id", valid_id_b, e.vld);
      end
    end
  endtask

  initial begin
    // reset
    step(1, 32'h0, NOP, 0, 0, 0, 0, 0, 0);
    // reset exit and sequential fetch
    step(0, 32'h0, NOP,          0, 0, 1, 32'h0, NOP,          0);
    chk32("a_stall_rst", stall_cycles_a, 32'd0);
    chk32("a_squash_rst", squash_slots_a, 32'd0);
    step(0, 32'h4, 32'h00500093, 0, 0, 1, 32'h0, 32'h00500093, 1);
    // 3-cycle stall holding 0x00A00113 while IMEM data changes
    step(0, 32'h8, 32'h00A00113, 1, 0, 1, 32'h4, 32'h00A00113, 1);
    step(0, 32'h8, 32'hDEADBEEF, 1, 0, 1, 32'h4, 32'h00A00113, 1);
    step(0, 32'h8, 32'hDEADBEEF, 1, 0, 1, 32'h4, 32'h00A00113, 1);
    step(0, 32'h8, 32'hDEADBEEF, 0, 0, 1, 32'h4, 32'h00A00113, 1);
    chk32("a_stall_3", stall_cycles_a, PERF ? 32'd3 : 32'd0);
    step(0, 32'hC, 32'h002081B3, 0, 0, 1, 32'h8, 32'h002081B3, 1);
    // single redirect: two squashed slots
    step(0, 32'h100, 32'h11111111, 0, 1, 1, 32'hC,   NOP, 0);
    step(0, 32'h104, 32'h22222222, 0, 0, 1, 32'h100, NOP, 0);
    step(0, 32'h108, 32'h00100193, 0, 0, 1, 32'h104, 32'h00100193, 1);
    chk32("a_squash_2", squash_slots_a, PERF ? 32'd2 : 32'd0);
    // redirect with stall, then re-redirect while one slot remains
    step(0, 32'h200, 32'h33333333, 1, 1, 1, 32'h108, NOP, 0);
    step(0, 32'h300, 32'h44444444, 0, 1, 1, 32'h200, NOP, 0);
    step(0, 32'h304, 32'h45454545, 0, 0, 1, 32'h300, NOP, 0);
    step(0, 32'h308, 32'h00000533, 0, 0, 1, 32'h304, 32'h00000533, 1);
    chk32("a_stall_redir", stall_cycles_a, PERF ? 32'd3 : 32'd0);
    chk32("a_squash_5", squash_slots_a, PERF ? 32'd5 : 32'd0);
    // reset in the middle of a stall with replay active
    step(0, 32'h30C, 32'h55555555, 1, 0, 1, 32'h308, 32'h55555555, 1);
    step(1, 32'h30C, 32'hDEADDEAD, 1, 0, 1, 32'h308, 32'h55555555, 1);
    chk32("a_stall_4", stall_cycles_a, PERF ? 32'd4 : 32'd0);
    step(0, 32'h400, 32'h66666666, 1, 0, 1, 32'h0, 32'h66666666, 0);
    chk32("a_stall_clr", stall_cycles_a, PERF ? 32'd0 : 32'd0);
    chk32("a_squash_clr", squash_slots_a, 32'd0);
    // still stalled since reset: replayed data, valid not yet set
    step(0, 32'h400, 32'h77777777, 0, 0, 1, 32'h0, 32'h66666666, 0);
    // FLUSH_DEPTH=3 instance: redirect then 2-cycle stall in the next slot
    step(0, 32'h404, 32'h88888888, 0, 0, 2, 32'h400, 32'h88888888, 1);
    step(0, 32'h500, 32'h99999999, 0, 1, 2, 32'h404, NOP, 0);
    step(0, 32'h504, 32'hAAAAAAAA, 1, 0, 2, 32'h500, NOP, 0);
    step(0, 32'h504, 32'hAAAAAAAA, 1, 0, 2, 32'h500, NOP, 0);
    step(0, 32'h504, 32'hAAAAAAAA, 0, 0, 2, 32'h500, NOP, 0);
    step(0, 32'h508, 32'hBBBBBBBB, 0, 0, 2, 32'h504, NOP, 0);
    step(0, 32'h50C, 32'hCCCCCCCC, 0, 0, 2, 32'h508, 32'hCCCCCCCC, 1);
    chk32("b_squash_3", squash_slots_b, PERF ? 32'd5 : 32'd0);
    chk32("b_stall_3", stall_cycles_b, PERF ? 32'd3 : 32'd0);
    step(0, 32'h510, 32'hDDDDDDDD, 0, 0, 2, 32'h50C, 32'hDDDDDDDD, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_pipe_reg.md
# if_id_pipe_reg

Parametrised IF/ID pipeline register for the in-order RISC-V core, placed between the fetch stage (PC generator plus synchronous instruction memory) and the decoder. It registers the fetch PC and presents the matching IMEM read data to decode. It supports:
- multi-cycle decode stalls, with a replay register that keeps the held instruction stable;
- a configurable squash depth after a control-flow redirect;
- an explicit valid bit that marks inserted bubbles.

## Interface
Parameters:
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction width in bits.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0), ILEN bits.
- FLUSH_DEPTH, 2, number of decode slots squashed per redirect; legal range 1..7.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_if  in  XLEN  PC currently issued to IMEM.
- instr_if  in  ILEN  IMEM read data; belongs to the PC held in pc_id.
- stall  in  1  decode hold (load-use or downstream stall).
- redirect  in  1  branch taken or jump resolved this cycle; squash request.
- pc_id  out  XLEN  registered PC of the decode-stage instruction.
- instr_id  out  ILEN  decode-stage instruction.
- valid_id  out  1  decode-stage slot holds a real instruction.
- stall_cycles  out  32  performance counter, see Configuration.
- squash_slots  out  32  performance counter, see Configuration.

## Operation
Internal state:
- pc_q, drives pc_id.
- hold_q, ILEN bits: last instruction presented.
- replay_q, 1 bit: previous cycle was a stall.
- sq_cnt, width clog2(FLUSH_DEPTH+1).
- valid_q.

Squash (sq_cnt reloads even if an earlier squash is still in progress):
- In any cycle with redirect=1: instr_id=NOP_INSTR, valid_id=0. At the clock edge, sq_cnt loads FLUSH_DEPTH-1.
- When sq_cnt!=0: instr_id=NOP_INSTR, valid_id=0.
- sq_cnt decrements only on cycles with stall=0 and redirect=0. It freezes during stall, so squashed slots stay squashed until they actually advance.

Instruction select, in priority order:
1. redirect or sq_cnt!=0: NOP_INSTR.
2. replay_q=1: hold_q.
3. Otherwise: instr_if.

hold_q and replay_q:
- hold_q loads the selected instr_id value every cycle.
- replay_q <= stall & ~redirect.
- A stall of N cycles therefore shows the same instr_id for N+1 cycles.

PC register:
- pc_q loads pc_if when stall=0 or redirect=1, and holds otherwise.
- redirect has priority over stall: pc_q loads and the replay path is cleared.

Valid:
- valid_q resets to 0.
- valid_q sets to 1 on the first cycle with stall=0 and redirect=0 after reset, and stays 1 thereafter.
- valid_id = valid_q & ~redirect & (sq_cnt==0).

## Timing
- pc_if → pc_id: 1 cycle.
- instr_if → instr_id: combinational (0 cycles). The IMEM synchronous read provides the one-cycle alignment.
- redirect in cycle t squashes decode slots t .. t+FLUSH_DEPTH-1, counted in non-stalled cycles. With the default of 2, slots t and t+1 are squashed.
- stall and redirect asserted together: treated as redirect. Stall is ignored that cycle.
- Reset in the cycle rst=1 is seen, regardless of stall, redirect or an in-progress squash. At the next edge:
  - pc_id=0, hold_q=NOP_INSTR, replay_q=0, sq_cnt=0, valid_id=0.
  - instr_id=instr_if, combinationally gated only by redirect.
  - Counters return to 0.
- Reset values of outputs: pc_id=0, valid_id=0, stall_cycles=0, squash_slots=0. instr_id=NOP_INSTR whenever redirect=1 in the reset-exit cycle.

## Configuration
- IF_ID_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with stall=1 and redirect=0.
  - squash_slots increments on every cycle in which instr_id is forced to NOP_INSTR by redirect or sq_cnt.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- IF_ID_PERF_CNT_EN not defined: both ports are tied to 32'd0 and no counter flops are generated. All other behaviour is identical.

## Test plan
- Reset, then pc_if=0x0,0x4,0x8 with instr_if=0x00500093,0x00A00113,0x002081B3 → pc_id lags pc_if by one cycle; instr_id=instr_if; valid_id=0 in the first cycle, then 1.
- 3-cycle stall while instr_id=0x00A00113, with instr_if changed to 0xDEADBEEF during the stall → instr_id=0x00A00113 for 4 cycles; pc_id constant; stall_cycles=3 (macro defined).
- Redirect for one cycle, FLUSH_DEPTH=2 → instr_id=0x00000013 and valid_id=0 for exactly 2 cycles, then the new-target instruction with valid_id=1; squash_slots=2.
- FLUSH_DEPTH=3, redirect then a 2-cycle stall in the next slot → 3 NOP slots spanning 5 cycles; sq_cnt holds during the stall.
- Redirect and stall in the same cycle, then a second redirect while sq_cnt=1 → pc_id loads pc_if; squash restarts with FLUSH_DEPTH-1 remaining.
- rst asserted mid-stall with replay active → the next cycle gives pc_id=0, valid_id=0, replay cleared (instr_id=instr_if), counters 0.
